fetch_seq: RTL and testbench

//  Fetch-stage sequencer for the rv32 pipeline. Owns the fetch PC, issues in-order instruction-memory

---
 rtl/rv32_pkg.sv | 19 +
 rtl/fetch_buf.sv | 82 ++++++++
 rtl/fetch_seq.sv | 142 ++++++++++++++
 tb/tb_fetch_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared rv32 fetch types and constants
// Purpose: fetch FSM state encoding, the canonical NOP word and the
//          {pc, instr} record carried through the fetch buffer.
package rv32_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - DEPTH-entry instruction buffer for the fetch stage
// Purpose: in-order FIFO of fetch_entry_t. Implemented as a shift register so
//          the head is always entry 0 and comes straight from a flop.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   push, push_entry  write one entry at the tail
//   pop               drop the head entry (ignored when empty)
//   flush             empty the buffer; overrides push and pop
//   head              entry 0 (NOP / RESET_PC after reset)
//   count             number of valid entries
module fetch_buf
  import rv32_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int         CW       = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE     = CW'(1);

  fetch_entry_t  ent_q [DEPTH];
  fetch_entry_t  ent_d [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] wr_idx;
  logic          do_push, do_pop;

  always_comb begin
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q < DEPTH_C) || do_pop);
    // When popping, everything shifts down one slot, so the tail moves too.
    wr_idx  = do_pop ? (count_q - ONE) : count_q;

    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
    end
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        ent_d[i] = ent_q[i + 1];
      end
    end
    if (do_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == wr_idx) begin
          ent_d[i] = push_entry;
        end
      end
    end

    count_d = count_q;
    if (do_push) count_d = count_d + ONE;
    if (do_pop)  count_d = count_d - ONE;
    if (flush)   count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '{pc: RESET_PC, instr: RV32_NOP};
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

  assign head  = ent_q[0];
  assign count = count_q;

endmodule

// File: rtl/fetch_seq.sv
// rtl/fetch_seq.sv - rv32 fetch-stage sequencer
// Purpose: owns the fetch PC, issues in-order imem requests, buffers returned
//          instructions with their PCs, and applies execute redirects by
//          flushing the buffer and dropping responses still in flight.
// Ports:
//   clk, rst                        clock, synchronous active-low reset
//   imem_req_valid/addr/ready       instruction memory request handshake
//   imem_rsp_valid/data             in-order instruction responses
//   redirect_valid/pc               single-cycle redirect from execute
//   de_valid/instr/pc, de_ready     instruction handshake towards decode
module fetch_seq
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        de_valid,
  output logic [31:0] de_instr,
  output logic [31:0] de_pc,
  input  logic        de_ready
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE     = CW'(1);

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [31:0]   target;
  logic          req_valid, fire, rsp_keep;
  logic [CW-1:0] outstanding, redir_drop;
  logic          buf_pop, buf_flush;
  fetch_entry_t  buf_head;
  logic [CW-1:0] buf_count;

  assign target = {redirect_pc[31:2], 2'b00};

  always_comb begin
    req_valid = (state_q == FETCH) && !redirect_valid &&
                ((inflight_q + buf_count) < DEPTH_C);
    fire      = req_valid && imem_req_ready;
    // A response is kept only in FETCH with nothing to drop; a response with
    // nothing outstanding is a protocol error and is ignored.
    rsp_keep  = imem_rsp_valid && (state_q == FETCH) && (drop_q == '0) &&
                (inflight_q != '0) && !redirect_valid;

    // In FLUSH the live in-flight count is held in drop_q; inflight_q is 0.
    outstanding = (state_q == FLUSH) ? drop_q : inflight_q;
    redir_drop  = (imem_rsp_valid && (outstanding != '0)) ? (outstanding - ONE)
                                                          : outstanding;

    state_d    = state_q;
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;

    case (state_q)
      HOLD: begin
        state_d = FETCH;
        if (redirect_valid) begin
          pc_d      = target;
          resp_pc_d = target;
        end
      end
      FETCH, FLUSH: begin
        if (redirect_valid) begin
          pc_d       = target;
          resp_pc_d  = target;
          inflight_d = '0;
          drop_d     = redir_drop;
          state_d    = (redir_drop != '0) ? FLUSH : FETCH;
        end else begin
          if (fire)     pc_d      = pc_q + 32'd4;
          if (rsp_keep) resp_pc_d = resp_pc_q + 32'd4;
          if (fire)     inflight_d = inflight_d + ONE;
          if (rsp_keep) inflight_d = inflight_d - ONE;
          if ((state_q == FLUSH) && imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - ONE;
          end
          if ((state_q == FLUSH) && (drop_d == '0)) begin
            state_d = FETCH;
          end
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= HOLD;
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  assign buf_pop   = de_valid && de_ready;
  assign buf_flush = redirect_valid && (state_q != HOLD);

  fetch_buf #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (rsp_keep),
    .push_entry ('{pc: resp_pc_q, instr: imem_rsp_data}),
    .pop        (buf_pop),
    .flush      (buf_flush),
    .head       (buf_head),
    .count      (buf_count)
  );

  assign imem_req_valid = req_valid;
  assign imem_req_addr  = pc_q;
  assign de_valid       = (buf_count != '0);
  assign de_instr       = buf_head.instr;
  assign de_pc          = buf_head.pc;

endmodule

// File: tb/tb_fetch_seq.sv
// tb/tb_fetch_seq.sv - directed bench for fetch_seq
module tb_fetch_seq;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        de_valid;
  logic [31:0] de_instr;
  logic [31:0] de_pc;
  logic        de_ready;

  fetch_seq dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .de_valid       (de_valid),
    .de_instr       (de_instr),
    .de_pc          (de_pc),
    .de_ready       (de_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic        mem_hold;
  logic [31:0] q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One clock: memory accepts a fired request, answers the oldest pending
  // request one cycle later unless held, and redirect pulses are cleared.
  task automatic tick();
    logic        f;
    logic [31:0] a;
    f = imem_req_valid && imem_req_ready;
    a = imem_req_addr;
    @(posedge clk);
    #1;
    if (!rst) q.delete();
    else if (f) q.push_back(a);
    if (rst && !mem_hold && q.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    redirect_valid = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    redirect_valid = 1'b0;
    mem_hold = 1'b0;
    tick();
    tick();
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_de_valid", {31'd0, de_valid}, 32'd0);
    chk("rst_de_instr", de_instr, 32'h0000_0013);
    chk("rst_de_pc", de_pc, 32'h0);
    rst = 1'b1;
  endtask

  task automatic chk_out(input string nm, input logic rv, input logic [31:0] addr,
                         input logic dv, input logic [31:0] pc);
    chk({nm, "_req_valid"}, {31'd0, imem_req_valid}, {31'd0, rv});
    if (rv) chk({nm, "_req_addr"}, imem_req_addr, addr);
    chk({nm, "_de_valid"}, {31'd0, de_valid}, {31'd0, dv});
    if (dv) begin
      chk({nm, "_de_pc"}, de_pc, pc);
      chk({nm, "_de_instr"}, de_instr, mem_word(pc));
    end
  endtask

  typedef struct {
    logic        do_rst;
    logic        der;
    logic        rv;
    logic [31:0] addr;
    logic        dv;
    logic [31:0] pc;
  } vec_t;

  vec_t vt[15];

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    de_ready = 1'b1;
    mem_hold = 1'b0;

    // streaming with decode always ready, then decode stalled with DEPTH=2
    vt[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    vt[1]  = '{1'b0, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0};
    vt[2]  = '{1'b0, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h0};
    vt[4]  = '{1'b0, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4};
    vt[5]  = '{1'b0, 1'b1, 1'b1, 32'hC,  1'b0, 32'h0};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h8};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 32'h4,  1'b0, 32'h0};
    vt[10] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0};
    vt[11] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0};
    vt[12] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h0};
    vt[13] = '{1'b0, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4};
    vt[14] = '{1'b0, 1'b1, 1'b1, 32'hC,  1'b0, 32'h0};

    for (int i = 0; i < 15; i++) begin
      if (vt[i].do_rst) do_reset();
      de_ready = vt[i].der;
      #1;
      chk_out($sformatf("vec%0d", i), vt[i].rv, vt[i].addr, vt[i].dv, vt[i].pc);
      tick();
    end

    // redirect with two requests in flight: both responses dropped
    do_reset();
    de_ready = 1'b1;
    mem_hold = 1'b1;
    tick();
    chk_out("fl_a", 1'b1, 32'h0, 1'b0, 32'h0);
    tick();
    chk_out("fl_b", 1'b1, 32'h4, 1'b0, 32'h0);
    tick();
    chk_out("fl_full", 1'b0, 32'h0, 1'b0, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    mem_hold = 1'b0;
    #1;
    chk_out("fl_redir", 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk_out("fl_drop1", 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk_out("fl_drop2", 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk_out("fl_tgt", 1'b1, 32'h100, 1'b0, 32'h0);
    tick();
    chk_out("fl_tgt4", 1'b1, 32'h104, 1'b0, 32'h0);
    tick();
    chk_out("fl_out", 1'b0, 32'h0, 1'b1, 32'h100);

    // redirect coinciding with the only outstanding response
    do_reset();
    de_ready = 1'b1;
    tick();
    chk_out("co_a", 1'b1, 32'h0, 1'b0, 32'h0);
    tick();
    chk("co_rsp_pending", {31'd0, imem_rsp_valid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0203;
    #1;
    chk_out("co_redir", 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk_out("co_tgt", 1'b1, 32'h200, 1'b0, 32'h0);
    tick();
    chk_out("co_tgt4", 1'b1, 32'h204, 1'b0, 32'h0);
    tick();
    chk_out("co_out", 1'b0, 32'h0, 1'b1, 32'h200);

    // redirect during HOLD to the top word, then address wrap
    do_reset();
    de_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    #1;
    chk_out("wr_hold", 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk_out("wr_top", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    tick();
    chk_out("wr_zero", 1'b1, 32'h0, 1'b0, 32'h0);
    tick();
    chk_out("wr_out0", 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    tick();
    chk_out("wr_out1", 1'b1, 32'h4, 1'b1, 32'h0);

    // reset with a full buffer
    do_reset();
    de_ready = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk_out("mr_full", 1'b0, 32'h0, 1'b1, 32'h0);
    rst = 1'b0;
    tick();
    chk("mr_de_valid", {31'd0, de_valid}, 32'd0);
    chk("mr_de_instr", de_instr, 32'h0000_0013);
    chk("mr_de_pc", de_pc, 32'h0);
    chk("mr_req_valid", {31'd0, imem_req_valid}, 32'd0);
    rst = 1'b1;
    #1;
    chk("mr_hold_req", {31'd0, imem_req_valid}, 32'd0);
    tick();
    chk_out("mr_restart", 1'b1, 32'h0, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
